// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register with valid/ready handshake, flush-to-bubble and stall counter.
// Define PIPE_STAGE_SKID_EN to build the skid register and make in_ready flop-driven.
module pipe_stage_reg #(
   parameter int WIDTH  = 32,
   parameter int FIELDS = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [FIELDS*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [FIELDS*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]        stall_cnt
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t                        state_q, state_d;
   logic                          accept, pop;
   logic                          ld_main_in;
   logic [FIELDS-1:0][WIDTH-1:0]  main_q;
   logic                          out_valid_q;

   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN
   logic                          ld_skid, ld_main_skid;
   logic                          in_ready_q;
   logic [FIELDS-1:0][WIDTH-1:0]  skid_q;

   assign in_ready = in_ready_q;

   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_skid      = 1'b0;
      ld_main_skid = 1'b0;
      case (state_q)
         EMPTY: if (accept) begin
            ld_main_in = 1'b1;
            state_d    = ONE;
         end
         ONE: begin
            if (accept && pop) begin
               ld_main_in = 1'b1;
            end else if (accept) begin
               ld_skid = 1'b1;
               state_d = TWO;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: if (pop) begin
            ld_main_skid = 1'b1;
            state_d      = ONE;
         end
         default: state_d = EMPTY;
      endcase
   end

   // in_ready is registered from the next state so upstream never sees a comb path from out_ready.
   always_ff @(posedge clock) begin
      if (reset || flush) in_ready_q <= 1'b1;
      else                in_ready_q <= (state_d != TWO);
   end

   for (genvar k = 0; k < FIELDS; k++) begin : g_fld
      always_ff @(posedge clock) begin
         if (reset || flush)    skid_q[k] <= '0;
         else if (ld_skid)      skid_q[k] <= in_data[k*WIDTH +: WIDTH];
      end

      always_ff @(posedge clock) begin
         if (reset || flush)    main_q[k] <= '0;
         else if (ld_main_in)   main_q[k] <= in_data[k*WIDTH +: WIDTH];
         else if (ld_main_skid) main_q[k] <= skid_q[k];
      end
   end
`else
   assign in_ready = !out_valid || out_ready;

   always_comb begin
      state_d    = state_q;
      ld_main_in = 1'b0;
      case (state_q)
         EMPTY: if (accept) begin
            ld_main_in = 1'b1;
            state_d    = ONE;
         end
         ONE: begin
            if (accept)   ld_main_in = 1'b1;
            else if (pop) state_d    = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   for (genvar k = 0; k < FIELDS; k++) begin : g_fld
      always_ff @(posedge clock) begin
         if (reset || flush)  main_q[k] <= '0;
         else if (ld_main_in) main_q[k] <= in_data[k*WIDTH +: WIDTH];
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= (state_d != EMPTY);
      end
   end

   // Flush deliberately leaves the counter alone; only reset clears it.
   always_ff @(posedge clock) begin
      if (reset)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (3 fields x 8 bits, 4-bit stall counter), both skid builds.
module tb_pipe_stage_reg;

   localparam int WIDTH  = 8;
   localparam int FIELDS = 3;
   localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic                    clock = 1'b0;
   logic                    reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [FIELDS*WIDTH-1:0] in_data, out_data;
   logic [CNT_W-1:0]        stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_stage_reg #(.WIDTH(WIDTH), .FIELDS(FIELDS), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one word for one edge; report whether it was taken.
   task automatic offer(input logic [23:0] d, output bit acc);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      acc = in_ready;
      tick();
   endtask

   initial begin
      logic [23:0] vals [4];
      int          idx;
      bit          acc;

      vals[0] = 24'h10; vals[1] = 24'h11; vals[2] = 24'h12; vals[3] = 24'h0;

      // Reset held two cycles with a live input
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 24'hA5A5A5; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_in_ready",  in_ready,  1);

      // Streaming
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         offer(24'(i), acc);
         chk("stream_acc",   acc,       1);
         chk("stream_valid", out_valid, 1);
         chk("stream_data",  out_data,  i);
      end
      offer(24'h030201, acc);
      chk("pack_field0", out_data[7:0],   8'h01);
      chk("pack_field1", out_data[15:8],  8'h02);
      chk("pack_field2", out_data[23:16], 8'h03);
      in_valid = 1'b0;
      tick();
      chk("stream_drain_valid", out_valid, 0);
      chk("stream_stall_cnt",   stall_cnt, 0);

      // Backpressure
      idx = 0;
      out_ready = 1'b0;
      offer(vals[idx], acc); if (acc) idx++;
      chk("bp_acc0",  acc,       1);
      chk("bp_data0", out_data,  24'h10);
      offer(vals[idx], acc); if (acc) idx++;
      chk("bp_acc1",  acc,       SKID ? 1 : 0);
      chk("bp_hold1", out_data,  24'h10);
      chk("bp_stall1", stall_cnt, 1);
      offer(vals[idx], acc); if (acc) idx++;
      chk("bp_acc2",  acc,       0);
      chk("bp_hold2", out_data,  24'h10);
      chk("bp_stall2", stall_cnt, 2);
      out_ready = 1'b1;
      offer(vals[idx], acc); if (acc) idx++;
      chk("bp_pop11_valid", out_valid, 1);
      chk("bp_pop11_data",  out_data,  24'h11);
      chk("bp_stall3",      stall_cnt, 2);
      offer(vals[idx], acc); if (acc) idx++;
      chk("bp_acc12",  acc,      1);
      chk("bp_pop12",  out_data, 24'h12);
      chk("bp_count",  idx,      3);
      in_valid = 1'b0;
      tick();
      chk("bp_drain_valid", out_valid, 0);

      // Flush while full
      out_ready = 1'b0;
      offer(24'h20, acc);
      chk("fl_acc20", acc, 1);
      offer(24'h21, acc);
      chk("fl_acc21", acc, SKID ? 1 : 0);
      chk("fl_stall_pre", stall_cnt, 3);
      flush = 1'b1; in_valid = 1'b1; in_data = 24'h99; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("fl_valid",    out_valid, 0);
      chk("fl_data",     out_data,  0);
      chk("fl_in_ready", in_ready,  1);
      chk("fl_stall",    stall_cnt, 3);
      tick();
      chk("fl_after_valid", out_valid, 0);
      chk("fl_after_data",  out_data,  0);

      // Stall counter saturation
      out_ready = 1'b0;
      offer(24'h33, acc);
      in_valid = 1'b0;
      chk("sat_acc", acc, 1);
      repeat (11) tick();
      chk("sat_14", stall_cnt, 14);
      tick();
      chk("sat_15", stall_cnt, 15);
      repeat (8) tick();
      chk("sat_hold",       stall_cnt, 15);
      chk("sat_data_hold",  out_data,  24'h33);
      chk("sat_valid_hold", out_valid, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("sat_flush_keep",  stall_cnt, 15);
      chk("sat_flush_valid", out_valid, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("sat_reset_clear", stall_cnt, 0);
      chk("sat_reset_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
